// File: rtl/z8_fetch_unit.sv
// z8 instruction fetch stage: reads byte-wide program memory and assembles
// 1..3 byte instructions for the decoder over a valid/ready handshake.
//
// state | meaning
// REQ   | issue opcode read at pc
// OPC   | capture opcode, decode length, read op1 if needed
// OP1   | capture op1, read op2 if needed
// OP2   | capture op2
// OUT   | instruction presented, wait for instr_ready
module z8_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [7:0]        instr_op1,
  output logic [7:0]        instr_op2,
  output logic [1:0]        instr_len,
  output logic              instr_illegal,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr
);

  typedef enum logic [2:0] {REQ, OPC, OP1, OP2, OUT} state_t;

  localparam logic [7:0] LAST_OPCODE = 8'd27;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        rdata_len;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;

  function automatic logic [1:0] decode_len(input logic [7:0] op);
    if (op == 8'd0 || op > LAST_OPCODE)
      decode_len = 2'd1;
    else if (op <= 8'd5 || op >= 8'd26)
      decode_len = 2'd3;
    else
      decode_len = 2'd2;
  endfunction

  assign rdata_len = decode_len(mem_rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= REQ;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: state_d = OPC;
      OPC: state_d = (rdata_len == 2'd1) ? OUT : OP1;
      OP1: state_d = (instr_len == 2'd3) ? OP2 : OUT;
      OP2: state_d = OUT;
      OUT: if (instr_ready) state_d = REQ;
      default: state_d = REQ;
    endcase
    if (redirect_valid)
      state_d = REQ;
  end

  // Read strobe is suppressed during reset and in a redirect cycle so that
  // no read targets the abandoned instruction stream.
  always_comb begin
    rd_req  = 1'b0;
    rd_addr = pc_q;
    case (state_q)
      REQ: rd_req = 1'b1;
      OPC: begin
        if (rdata_len != 2'd1) begin
          rd_req  = 1'b1;
          rd_addr = pc_q + ADDR_W'(1);
        end
      end
      OP1: begin
        if (instr_len == 2'd3) begin
          rd_req  = 1'b1;
          rd_addr = pc_q + ADDR_W'(2);
        end
      end
      default: rd_req = 1'b0;
    endcase
    if (redirect_valid || rst)
      rd_req = 1'b0;
    mem_rd      = rd_req;
    mem_addr    = rd_req ? rd_addr : '0;
    instr_valid = (state_q == OUT);
  end

  // Captures are skipped on redirect; returning data for the old stream then
  // lands in REQ, where nothing samples it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      instr_opcode  <= 8'd0;
      instr_op1     <= 8'd0;
      instr_op2     <= 8'd0;
      instr_len     <= 2'd1;
      instr_illegal <= 1'b0;
      instr_pc      <= '0;
    end else if (redirect_valid) begin
      pc_q <= redirect_addr;
    end else begin
      case (state_q)
        OPC: begin
          instr_opcode  <= mem_rdata;
          instr_op1     <= 8'd0;
          instr_op2     <= 8'd0;
          instr_len     <= rdata_len;
          instr_illegal <= (mem_rdata > LAST_OPCODE);
          instr_pc      <= pc_q;
        end
        OP1: instr_op1 <= mem_rdata;
        OP2: instr_op2 <= mem_rdata;
        OUT: if (instr_ready) pc_q <= pc_q + ADDR_W'(instr_len);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z8_fetch_unit.sv
// Self-checking bench for z8_fetch_unit: memory model, expected-read and
// expected-instruction queues built from the memory image.
module tb_z8_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'hEE;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode, instr_op1, instr_op2;
  logic [1:0] instr_len;
  logic       instr_illegal;
  logic [7:0] instr_pc;
  logic       redirect_valid;
  logic [7:0] redirect_addr;

  z8_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h10)) dut (
    .clk(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_op1(instr_op1), .instr_op2(instr_op2),
    .instr_len(instr_len), .instr_illegal(instr_illegal), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'hEE;

  typedef struct {
    logic [7:0] opc, op1, op2, pc;
    logic [1:0] len;
    logic       ill;
  } instr_t;

  instr_t     exp_q[$];
  logic [7:0] addr_q[$];
  instr_t     mon_e;
  int         n_chk = 0, n_fail = 0, cyc = 0, last_hs = 0;
  bit         tput = 1'b0, have_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] len_of(input logic [7:0] op);
    if (op == 8'd0 || op > 8'd27) return 2'd1;
    if (op <= 8'd5 || op >= 8'd26) return 2'd3;
    return 2'd2;
  endfunction

  // Expected reads/instructions for n instructions from start, plus the reads
  // of the following instruction, which the DUT fetches and then stalls on.
  task automatic push_prog(input logic [7:0] start, input int n);
    logic [7:0] pc, a1, a2;
    instr_t e;
    pc = start;
    for (int k = 0; k <= n; k++) begin
      a1 = pc + 8'd1;
      a2 = pc + 8'd2;
      e.pc  = pc;
      e.opc = mem[pc];
      e.len = len_of(e.opc);
      e.ill = (e.opc > 8'd27);
      e.op1 = (e.len >= 2'd2) ? mem[a1] : 8'd0;
      e.op2 = (e.len == 2'd3) ? mem[a2] : 8'd0;
      addr_q.push_back(pc);
      if (e.len >= 2'd2) addr_q.push_back(a1);
      if (e.len == 2'd3) addr_q.push_back(a2);
      if (k < n) exp_q.push_back(e);
      pc = pc + {6'd0, e.len};
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (mem_rd) begin
        if (addr_q.size() == 0) check("rd_unexpected", mem_rd, 0);
        else check("rd_addr", mem_addr, addr_q.pop_front());
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) check("hs_unexpected", instr_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("opcode", instr_opcode, mon_e.opc);
          check("op1", instr_op1, mon_e.op1);
          check("op2", instr_op2, mon_e.op2);
          check("len", instr_len, mon_e.len);
          check("illegal", instr_illegal, mon_e.ill);
          check("pc", instr_pc, mon_e.pc);
          if (tput && have_last) check("gap", cyc - last_hs, mon_e.len + 2);
          last_hs   = cyc;
          have_last = 1'b1;
        end
      end
    end
  end

  task automatic run_seg(input bit stall, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      instr_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      n++;
    end
    check("seg_done", exp_q.size(), 0);
    @(posedge clk); #1;
    instr_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("tail_rds", addr_q.size(), 0);
    check("tail_wait", instr_valid, 1);
  endtask

  task automatic redirect_to(input logic [7:0] a);
    @(posedge clk); #1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = a;
    addr_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("redirect_no_rd", mem_rd, 0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hC3 ^ 8'(i);
    {mem[8'h10], mem[8'h11], mem[8'h12]} = {8'h02, 8'h05, 8'hA7};
    {mem[8'h13], mem[8'h14]}             = {8'h0A, 8'h03};
    mem[8'h15] = 8'h00;
    mem[8'h16] = 8'h30;
    {mem[8'h17], mem[8'h18], mem[8'h19]} = {8'h1B, 8'h11, 8'h22};
    {mem[8'h1A], mem[8'h1B]}             = {8'h06, 8'h44};
    {mem[8'h1C], mem[8'h1D]}             = {8'h19, 8'h55};
    mem[8'h1E] = 8'h1C;
    {mem[8'h1F], mem[8'h20], mem[8'h21]} = {8'h01, 8'hAB, 8'hCD};
    {mem[8'hFE], mem[8'hFF], mem[8'h00]} = {8'h1A, 8'h07, 8'h00};
    {mem[8'h01], mem[8'h02], mem[8'h03]} = {8'h30, 8'h00, 8'h1C};
    {mem[8'h80], mem[8'h81], mem[8'h82]} = {8'h03, 8'h77, 8'h88};
    {mem[8'h40], mem[8'h41]}             = {8'h0C, 8'h66};
    {mem[8'h42], mem[8'h43], mem[8'h44]} = {8'h1B, 8'h01, 8'h02};
    mem[8'h45] = 8'h00;

    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", instr_opcode, 0);
    check("rst_op1", instr_op1, 0);
    check("rst_op2", instr_op2, 0);
    check("rst_len", instr_len, 1);
    check("rst_illegal", instr_illegal, 0);
    check("rst_pc", instr_pc, 0);

    // Stream from RESET_PC: latency, 5-cycle stall, then full throughput
    push_prog(8'h10, 9);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) check("first_rd", mem_rd, 1);
      if (c == 3) check("len3_lat_early", instr_valid, 0);
      if (c == 4) check("len3_lat", instr_valid, 1);
    end
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", instr_valid, 1);
      check("hold_no_rd", mem_rd, 0);
      check("hold_opcode", instr_opcode, exp_q[0].opc);
      check("hold_op2", instr_op2, exp_q[0].op2);
      check("hold_pc", instr_pc, exp_q[0].pc);
    end
    tput = 1'b1; have_last = 1'b0;
    run_seg(1'b0, 100);
    tput = 1'b0;

    // Operand address wrap across 0xFF
    redirect_to(8'hFE);
    push_prog(8'hFE, 4);
    @(negedge clk);
    check("valid_drop", instr_valid, 0);
    run_seg(1'b1, 200);

    // NOP at 0x00: valid two cycles after the request
    redirect_to(8'h00);
    push_prog(8'h00, 3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) check("len1_lat_early", instr_valid, 0);
      if (c == 2) check("len1_lat", instr_valid, 1);
    end
    tput = 1'b1; have_last = 1'b0;
    run_seg(1'b0, 100);
    tput = 1'b0;

    // Redirect during OP1 of a 3-byte instruction at 0x80
    redirect_to(8'h80);
    addr_q.push_back(8'h80);
    addr_q.push_back(8'h81);
    @(posedge clk);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    check("abort_rds", addr_q.size(), 0);
    @(negedge clk);
    check("abort_no_rd", mem_rd, 0);
    check("abort_valid", instr_valid, 0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    push_prog(8'h40, 3);
    @(negedge clk);
    check("abort_target_rd", mem_rd, 1);
    run_seg(1'b1, 200);

    // Reset while in OP2
    redirect_to(8'h10);
    addr_q.push_back(8'h10);
    addr_q.push_back(8'h11);
    addr_q.push_back(8'h12);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("op2rst_rds", addr_q.size(), 0);
    check("op2rst_mem_rd", mem_rd, 0);
    check("op2rst_mem_addr", mem_addr, 0);
    check("op2rst_valid", instr_valid, 0);
    check("op2rst_opcode", instr_opcode, 0);
    check("op2rst_op1", instr_op1, 0);
    check("op2rst_len", instr_len, 1);
    check("op2rst_pc", instr_pc, 0);
    repeat (2) @(negedge clk);
    addr_q.delete();
    exp_q.delete();
    push_prog(8'h10, 2);
    @(posedge clk); #1;
    rst = 1'b0;
    tput = 1'b1; have_last = 1'b0;
    @(negedge clk);
    check("restart_rd", mem_rd, 1);
    run_seg(1'b0, 100);
    tput = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/z8_fetch_unit.md
# z8_fetch_unit

Instruction fetch stage of the z8 processor core, sitting directly upstream of the decoder that consumes `instruction_set::OPCODES`. It reads the byte-wide program memory and assembles variable-length instructions (opcode plus 0–2 operand bytes) whose length depends on the opcode. It presents each complete instruction to the decoder over a valid/ready handshake and accepts PC redirects from branch resolution.

## Interface
- `ADDR_W`, 8: program address width; PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk`  in  1  single core clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_rd`  out  1  program memory read strobe.
- `mem_addr`  out  ADDR_W  read address; meaningful only while `mem_rd`=1.
- `mem_rdata`  in  8  read data, valid exactly 1 cycle after the `mem_rd` cycle.
- `instr_valid`  out  1  assembled instruction available.
- `instr_ready`  in  1  decoder accepts the instruction this cycle.
- `instr_opcode`  out  8  opcode byte.
- `instr_op1`, `instr_op2`  out  8 each  operand bytes; 0 when not part of the instruction.
- `instr_len`  out  2  instruction length in bytes, 1..3.
- `instr_illegal`  out  1  opcode is outside the OPCODES range (>27).
- `instr_pc`  out  ADDR_W  address of the opcode byte.
- `redirect_valid`  in  1  PC redirect (taken JMP/JZ/JNZ/JN).
- `redirect_addr`  in  ADDR_W  redirect target.

## Operation
- Length decode by opcode value:
  - Length 1: NOP (0), and any illegal opcode (28–255).
  - Length 3: LDD, LDD_I, LDR, STR, STR_I (1–5), SB, CB (26–27).
  - Length 2: all others (6–25).
- FSM states: REQ, OPC, OP1, OP2, OUT.
- REQ: `mem_rd`=1, `mem_addr`=pc; go to OPC.
- OPC: capture `mem_rdata` as opcode and decode the length.
  - Length 1: go to OUT.
  - Otherwise: issue a read at pc+1 in the same cycle and go to OP1.
- OP1: capture op1.
  - Length 3: issue a read at pc+2 and go to OP2.
  - Otherwise: go to OUT.
- OP2: capture op2; go to OUT.
- OUT: `instr_valid`=1; all `instr_*` outputs are registered and held stable until `instr_valid && instr_ready`. On handshake: pc <= pc+len (mod 2^ADDR_W); go to REQ.
- Operand addresses also wrap: an instruction at 0xFF with length 3 reads 0xFF, 0x00, 0x01.
- `redirect_valid` in any state:
  - Abort the current assembly: pc <= `redirect_addr`, next state REQ, `instr_valid` drops next cycle.
  - Any read data returning the following cycle is ignored.
  - Redirect has priority over a simultaneous handshake: the decoder's accept stands, but pc comes from `redirect_addr`.
  - No `mem_rd` is issued in the redirect cycle.
- Reset (asynchronous, any state): state REQ, pc=RESET_PC, `mem_rd`=0, `mem_addr`=0, `instr_valid`=0, `instr_opcode`/`op1`/`op2`=0, `instr_len`=1, `instr_illegal`=0, `instr_pc`=0. Any in-flight read is discarded.

## Timing
- The first `mem_rd` is in the first cycle after `rst` deasserts.
- Read-to-data latency: exactly 1 cycle; at most one read outstanding; reads are never issued back-to-back without an intervening capture.
- Cycles from REQ to `instr_valid`: 2 for length 1, 3 for length 2, 4 for length 3.
- Minimum cycles per instruction with `instr_ready` held at 1: 3 / 4 / 5 for lengths 1 / 2 / 3.
- `instr_ready` is ignored while `instr_valid`=0.
- Outputs do not change while waiting for `instr_ready`.
- Redirect takes effect on the next edge; the first read of the target is issued 1 cycle after the `redirect_valid` cycle.

## Test plan
- Memory holds 0x00 at 0x00: reset, `instr_ready`=1 -> `instr_valid` in cycle 2 with opcode 0x00, len 1, op1=op2=0, pc 0; next read at address 0x01.
- Memory holds 0x02,0x05,0xA7 (LDD_I r5,#0xA7) at 0x10 with RESET_PC=0x10 -> reads at 0x10, 0x11, 0x12; output opcode 0x02, op1 0x05, op2 0xA7, len 3, pc 0x10; next fetch at 0x13.
- Memory holds 0x0A,0x03 (INC r3); hold `instr_ready`=0 for 5 cycles -> outputs stable, no `mem_rd`; raise ready -> handshake, then fetch at pc+2.
- Memory holds 0x1A (SB) at 0xFE -> operand reads at 0xFF then 0x00; next PC is 0x01; opcode 0x30 -> `instr_illegal`=1, len 1.
- `redirect_valid` with target 0x40 asserted during OP1 -> no `instr_valid` for the aborted instruction; next `mem_rd` at 0x40 one cycle later; the stale byte is dropped.
- `rst` asserted mid-OP2 -> all outputs reach their reset values immediately; after release, fetch restarts at RESET_PC.
